// File: rtl/int8_mac_pkg.sv
// Shared definitions for the int8 MAC cluster: lane geometry, datapath widths,
// accumulator clamp limits and the dot-product sequencer state encoding.
package int8_mac_pkg;

  localparam int unsigned LANES  = 8;   // int8 lanes per operand beat
  localparam int unsigned DATA_W = 8;   // operand width
  localparam int unsigned PROD_W = 16;  // signed 8x8 product width
  localparam int unsigned TREE_W = 19;  // sum of 8 products, range +/-131072
  localparam int unsigned ACC_W  = 32;  // accumulator / result width

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/int8_mac_tree.sv
// Combinational int8 multiply-add tree: 8 signed 8x8 products summed to 19 bits.
// Ports:
//   op       in  16 operands of DATA_W bits; operand i = op[8i+7:8i], and
//            product k multiplies operand 2k by operand 2k+1
//   sum      out signed sum of the 8 products (TREE_W bits)
//   prod_dbg out individual signed products, product k = prod_dbg[16k+15:16k]
module int8_mac_tree
  import int8_mac_pkg::*;
(
  input  logic [2*LANES*DATA_W-1:0] op,
  output logic [TREE_W-1:0]         sum,
  output logic [LANES*PROD_W-1:0]   prod_dbg
);

  logic signed [PROD_W-1:0] prod [LANES];
  logic signed [PROD_W:0]   lvl1 [LANES/2];
  logic signed [PROD_W+1:0] lvl2 [LANES/4];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    assign a = op[2*k*DATA_W +: DATA_W];
    assign b = op[(2*k+1)*DATA_W +: DATA_W];
    assign prod[k] = PROD_W'(a) * PROD_W'(b);
    assign prod_dbg[k*PROD_W +: PROD_W] = prod[k];
  end

  // Each level widens by one bit so no partial sum can wrap.
  for (genvar i = 0; i < LANES/2; i++) begin : g_lvl1
    assign lvl1[i] = (PROD_W+1)'(prod[2*i]) + (PROD_W+1)'(prod[2*i+1]);
  end

  for (genvar i = 0; i < LANES/4; i++) begin : g_lvl2
    assign lvl2[i] = (PROD_W+2)'(lvl1[2*i]) + (PROD_W+2)'(lvl1[2*i+1]);
  end

  assign sum = TREE_W'(lvl2[0]) + TREE_W'(lvl2[1]);

endmodule

// File: rtl/int8_dot_seq.sv
// Multi-beat int8 dot-product sequencer. A job of cfg_len beats streams through
// one int8_mac_tree; each beat's 19-bit sum is registered (stage P) and then
// added into a saturating 32-bit accumulator. One result is returned per job.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, cfg_len        job request (taken only when idle) and beat count
//   abort                 synchronous job cancel, no result produced
//   busy                  high whenever not idle
//   in_valid/in_ready     operand beat handshake; in_a/in_b hold 8 int8 lanes
//   out_valid/out_ready   result handshake; out_data signed saturated result,
//                         out_ovf set if the job saturated
module int8_dot_seq
  import int8_mac_pkg::*;
#(
  parameter int unsigned LEN_W = 16,
  parameter int unsigned ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic                    abort,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_data,
  output logic                    out_ovf
);

  state_t state_q, state_d;

  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              p_valid_q, p_valid_d;
  logic [TREE_W-1:0] p_sum_q, p_sum_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic              out_ovf_q, out_ovf_d;

  logic [2*LANES*DATA_W-1:0] tree_op;
  logic [TREE_W-1:0]         tree_sum;
  logic                      accept;
  logic [ACC_W:0]            sum_wide;
  logic [ACC_W-1:0]          acc_sat;
  logic                      sat_hit;

  // Lane k of a and b feed tree operands 2k and 2k+1.
  always_comb begin
    tree_op = '0;
    for (int k = 0; k < LANES; k++) begin
      tree_op[2*k*DATA_W +: DATA_W]     = in_a[k*DATA_W +: DATA_W];
      tree_op[(2*k+1)*DATA_W +: DATA_W] = in_b[k*DATA_W +: DATA_W];
    end
  end

  int8_mac_tree u_tree (
    .op       (tree_op),
    .sum      (tree_sum),
    .prod_dbg ()
  );

  assign busy     = (state_q != IDLE);
  assign in_ready = (state_q == RUN) && (remain_q != '0) && !abort;
  assign accept   = in_valid && in_ready;

  // 33-bit add of the accumulator and the sign-extended P sum; a mismatch of
  // the top two bits means the true result left the 32-bit signed range.
  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q}
             + {{(ACC_W+1-TREE_W){p_sum_q[TREE_W-1]}}, p_sum_q};
    sat_hit  = 1'b0;
    acc_sat  = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      sat_hit = 1'b1;
      acc_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    p_valid_d   = 1'b0;
    p_sum_d     = p_sum_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    if (p_valid_q) begin
      acc_d = acc_sat;
      if (sat_hit) begin
        ovf_d = 1'b1;
      end
    end

    if (accept) begin
      p_valid_d = 1'b1;
      p_sum_d   = tree_sum;
      remain_d  = remain_q - LEN_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          remain_d = cfg_len;
          acc_d    = '0;
          ovf_d    = 1'b0;
          state_d  = (cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept && (remain_q == LEN_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Final P entry lands in the accumulator on this edge.
        state_d = DONE;
      end
      DONE: begin
        // First DONE cycle captures the settled accumulator into the output
        // register; the result then holds until the consumer takes it.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_q;
          out_ovf_d   = ovf_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      remain_d    = '0;
      p_valid_d   = 1'b0;
      p_sum_d     = '0;
      acc_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remain_q    <= '0;
      p_valid_q   <= 1'b0;
      p_sum_q     <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      p_valid_q   <= p_valid_d;
      p_sum_q     <= p_sum_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_int8_dot_seq.sv
// Directed self-checking bench for int8_dot_seq.
module tb_int8_dot_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] cfg_len;
  logic        abort;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;

  int n_checks;
  int n_errors;

  int8_dot_seq #(
    .LEN_W (16),
    .ACC_W (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_len   (cfg_len),
    .abort     (abort),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)",
               tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rep(input logic [7:0] v);
    return {8{v}};
  endfunction

  task automatic start_job(input logic [15:0] len);
    start   = 1'b1;
    cfg_len = len;
    tick();
    start   = 1'b0;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input string tag, input logic [7:0] a, input logic [7:0] b);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_a     = rep(a);
    in_b     = rep(b);
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check_eq(tag, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int waited;
    waited = 0;
    while (!out_valid && waited < 20) begin
      tick();
      waited++;
    end
    check_eq(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    int cyc;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    cfg_len   = '0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single beat: 8 lanes * 3*4 = 96, valid two edges after the accept edge
    start_job(16'd1);
    check_eq("t1_busy", 32'(busy), 32'd1);
    in_valid = 1'b1;
    in_a     = rep(8'd3);
    in_b     = rep(8'd4);
    check_eq("t1_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("t1_valid_n1", 32'(out_valid), 32'd0);
    tick();
    check_eq("t1_valid_n2", 32'(out_valid), 32'd0);
    tick();
    check_eq("t1_valid_n3", 32'(out_valid), 32'd1);
    check_eq("t1_data", out_data, 32'd96);
    check_eq("t1_ovf", 32'(out_ovf), 32'd0);
    take_out();
    check_eq("t1_valid_drop", 32'(out_valid), 32'd0);
    check_eq("t1_idle", 32'(busy), 32'd0);

    // Multi-beat with gaps: 4 * 8 * 16384 = 524288
    start_job(16'd4);
    in_a = rep(8'h80);
    in_b = rep(8'h80);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = (i % 2 == 0);
      if (in_valid && in_ready) n++;
      tick();
    end
    in_valid = 1'b0;
    check_eq("t2_beats", n, 32'd4);
    wait_out("t2_wait");
    check_eq("t2_data", out_data, 32'd524288);
    check_eq("t2_ovf", 32'(out_ovf), 32'd0);
    take_out();

    // Mixed signs: 8*(127*-128) + 8*(-1*1) = -130056
    start_job(16'd2);
    send_beat("t3_b0", 8'h7f, 8'h80);
    send_beat("t3_b1", 8'hff, 8'h01);
    wait_out("t3_wait");
    check_eq("t3_data", out_data, 32'(-130056));
    check_eq("t3_ovf", 32'(out_ovf), 32'd0);
    take_out();

    // Saturation: 16384 beats of +131072 reach 2^31 and clamp
    start_job(16'd16400);
    in_valid = 1'b1;
    in_a     = rep(8'h80);
    in_b     = rep(8'h80);
    n   = 0;
    cyc = 0;
    while (n < 16400 && cyc < 17000) begin
      if (in_ready) n++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("t4_beats", n, 32'd16400);
    wait_out("t4_wait");
    check_eq("t4_data", out_data, 32'h7fff_ffff);
    check_eq("t4_ovf", 32'(out_ovf), 32'd1);
    take_out();
    start_job(16'd1);
    send_beat("t4_next_b0", 8'd1, 8'd1);
    wait_out("t4_next_wait");
    check_eq("t4_next_data", out_data, 32'd8);
    check_eq("t4_next_ovf", 32'(out_ovf), 32'd0);
    take_out();

    // Zero length and output backpressure
    start_job(16'd0);
    check_eq("t5_busy", 32'(busy), 32'd1);
    wait_out("t5_wait");
    for (int i = 0; i < 5; i++) begin
      check_eq("t5_hold_valid", 32'(out_valid), 32'd1);
      check_eq("t5_hold_data", out_data, 32'd0);
      check_eq("t5_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    // start alongside the handshake is ignored, taken the cycle after
    start     = 1'b1;
    cfg_len   = 16'd1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("t5_b2b_idle", 32'(busy), 32'd0);
    check_eq("t5_valid_drop", 32'(out_valid), 32'd0);
    tick();
    start = 1'b0;
    check_eq("t5_b2b_taken", 32'(busy), 32'd1);
    send_beat("t5_b2b_b0", 8'd1, 8'd1);
    wait_out("t5_b2b_wait");
    check_eq("t5_b2b_data", out_data, 32'd8);
    take_out();

    // Abort after 3 beats
    start_job(16'd8);
    for (int i = 0; i < 3; i++) send_beat("t6_beat", 8'd5, 8'd5);
    in_valid = 1'b1;
    abort    = 1'b1;
    #1;
    check_eq("t6_abort_ready", 32'(in_ready), 32'd0);
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check_eq("t6_abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq("t6_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    start_job(16'd1);
    send_beat("t6_new_b0", 8'd2, 8'd2);
    wait_out("t6_new_wait");
    check_eq("t6_new_data", out_data, 32'd32);
    check_eq("t6_new_ovf", 32'(out_ovf), 32'd0);
    take_out();

    // Asynchronous reset mid-job
    start_job(16'd8);
    send_beat("t7_beat", 8'd2, 8'd2);
    send_beat("t7_beat", 8'd2, 8'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t7_rst_busy", 32'(busy), 32'd0);
    check_eq("t7_rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("t7_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("t7_rst_out_data", out_data, 32'd0);
    check_eq("t7_rst_out_ovf", 32'(out_ovf), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start_job(16'd1);
    send_beat("t7_new_b0", 8'd2, 8'd2);
    wait_out("t7_new_wait");
    check_eq("t7_new_data", out_data, 32'd32);
    take_out();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
